// File: rtl/tile_config_receiver.sv
// Configuration-bus receiver for one CGRA tile: filters beats by tile ID, writes a shadow
// bank, commits shadow to the active bank that drives the fabric, and serves readback/status.
module tile_config_receiver #(
  parameter logic [15:0] TILE_ID  = 16'h0001,
  parameter int          NUM_REGS = 8,
  parameter int          CNT_W    = 16
) (
  input  logic                     clk_in,
  input  logic                     reset_in,
  input  logic [31:0]              config_addr_in,
  input  logic [31:0]              config_data_in,
  input  logic                     config_read_in,
  input  logic                     config_commit_in,
  output logic [32*NUM_REGS-1:0]   cfg_active_out,
  output logic [31:0]              read_data_out,
  output logic                     read_valid_out,
  output logic                     config_err_out,
  output logic [CNT_W-1:0]         write_count_out
);

  localparam logic [8:0]  LP_NUM_REGS = 9'(NUM_REGS);
  localparam logic [31:0] LP_BAD_READ = 32'hDEAD_BEEF;

  // Stage 1: raw bus capture
  logic [31:0]      r_addr;
  logic [31:0]      r_data;
  logic             r_read;
  logic             r_commit;

  // Stage 2: banks and status
  logic [31:0]      r_shadow [NUM_REGS];
  logic [31:0]      r_active [NUM_REGS];
  logic [31:0]      r_read_data;
  logic             r_read_valid;
  logic             r_err;
  logic [CNT_W-1:0] r_count;

  logic             w_match;
  logic [7:0]       w_idx;
  logic             w_bad;
  logic             w_wr_ok;
  logic             w_rd;
  logic [NUM_REGS-1:0] w_wr_sel;
  logic [31:0]      w_rd_word;

  // TILE_ID is never 0, so an all-zero idle address can never match.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    w_match   = (r_addr[15:0] == TILE_ID);
    w_idx     = r_addr[31:24];
    w_bad     = ({1'b0, w_idx} >= LP_NUM_REGS) || (r_addr[23:16] != 8'd0);
    w_wr_ok   = w_match && !r_read && !w_bad;
    w_rd      = w_match && r_read;
    w_wr_sel  = '0;
    w_rd_word = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (w_idx == 8'(i)) begin
        w_wr_sel[i] = w_wr_ok;
        w_rd_word   = r_active[i];
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      r_addr       <= '0;
      r_data       <= '0;
      r_read       <= 1'b0;
      r_commit     <= 1'b0;
      // NOTE: the banks are flop arrays that must power up to a known idle fabric, so they are reset here;
      // a RAM-style array would not be.
      for (int i = 0; i < NUM_REGS; i++) begin
        r_shadow[i] <= '0;
        r_active[i] <= '0;
      end
      r_read_data  <= '0;
      r_read_valid <= 1'b0;
      r_err        <= 1'b0;
      r_count      <= '0;
    end else begin
      // NOTE: non-blocking assignments, so every stage-2 decision sees the pre-edge values of the banks.
      r_addr   <= config_addr_in;
      r_data   <= config_data_in;
      r_read   <= config_read_in;
      r_commit <= config_commit_in;

      for (int i = 0; i < NUM_REGS; i++) begin
        if (w_wr_sel[i]) r_shadow[i] <= r_data;
        // Write-first bypass: a write landing with the commit goes straight to active.
        if (r_commit) r_active[i] <= w_wr_sel[i] ? r_data : r_shadow[i];
      end

      if (w_match && w_bad) r_err <= 1'b1;

      r_read_valid <= w_rd;
      if (w_rd) r_read_data <= w_bad ? LP_BAD_READ : w_rd_word;

      if (w_wr_ok && (r_count != '1)) r_count <= r_count + 1'b1;
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_active_out
    assign cfg_active_out[32*g +: 32] = r_active[g];
  end

  assign read_data_out   = r_read_data;
  assign read_valid_out  = r_read_valid;
  assign config_err_out  = r_err;
  assign write_count_out = r_count;

endmodule
